// File: rtl/comparator_seq.sv
// Sequential magnitude comparator: captures two operands on start and compares
// them MSB first, one bit per clock, in unsigned or two's-complement mode.
// Results are registered and held until the next compare completes.
module comparator_seq #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_equal,
  output logic             o_not_equal,
  output logic             o_great_a,
  output logic             o_great_b
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              signed_q, signed_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              decided_q, decided_d;
  logic              win_a_q, win_a_d;
  logic              equal_q, equal_d;
  logic              not_equal_q, not_equal_d;
  logic              great_a_q, great_a_d;
  logic              great_b_q, great_b_d;

  // Per-bit evaluation of the current index
  logic bit_a, bit_b, bit_diff, sign_pos, bit_win_a;
  logic decided_fin, win_fin, last_bit, cmp_exit;

  // State and datapath registers; reset aborts any compare in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      idx_q       <= '0;
      decided_q   <= 1'b0;
      win_a_q     <= 1'b0;
      equal_q     <= 1'b0;
      not_equal_q <= 1'b0;
      great_a_q   <= 1'b0;
      great_b_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      idx_q       <= idx_d;
      decided_q   <= decided_d;
      win_a_q     <= win_a_d;
      equal_q     <= equal_d;
      not_equal_q <= not_equal_d;
      great_a_q   <= great_a_d;
      great_b_q   <= great_b_d;
    end
  end

  // Next-state logic: capture in idle, scan bits in compare, pulse done
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    idx_d       = idx_q;
    decided_d   = decided_q;
    win_a_d     = win_a_q;
    equal_d     = equal_q;
    not_equal_d = not_equal_q;
    great_a_d   = great_a_q;
    great_b_d   = great_b_q;

    bit_a    = a_q[idx_q];
    bit_b    = b_q[idx_q];
    bit_diff = bit_a ^ bit_b;
    // A set sign bit means negative, so the winner flips at the MSB in signed mode
    sign_pos  = signed_q && (idx_q == IdxW'(WIDTH - 1));
    bit_win_a = bit_a ^ sign_pos;
    // The first recorded difference is final; later bits never overwrite it
    decided_fin = decided_q | bit_diff;
    win_fin     = decided_q ? win_a_q : bit_win_a;
    last_bit    = (idx_q == '0);
    cmp_exit    = last_bit || ((EARLY_EXIT != 0) && bit_diff);

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          a_d       = i_a;
          b_d       = i_b;
          signed_d  = i_signed;
          idx_d     = IdxW'(WIDTH - 1);
          decided_d = 1'b0;
          win_a_d   = 1'b0;
          state_d   = StCmp;
        end
      end
      StCmp: begin
        decided_d = decided_fin;
        win_a_d   = win_fin;
        if (cmp_exit) begin
          equal_d     = ~decided_fin;
          not_equal_d = decided_fin;
          great_a_d   = decided_fin & win_fin;
          great_b_d   = decided_fin & ~win_fin;
          state_d     = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status and result outputs straight from registers
  always_comb begin
    o_busy      = (state_q != StIdle);
    o_done      = (state_q == StDone);
    o_equal     = equal_q;
    o_not_equal = not_equal_q;
    o_great_a   = great_a_q;
    o_great_b   = great_b_q;
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Scoreboard bench for comparator_seq: four instances (8-bit and 2-bit, with and
// without early exit) exercised one at a time; a monitor pops expected results
// on every o_done and checks values and done timing.
module tb_comparator_seq;

  logic       clk;
  logic       rst;
  logic [3:0] start_r;
  logic       sgn;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic [3:0] busy_w, done_w, eq_w, ne_w, ga_w, gb_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         id;
    logic [3:0] res;  // {equal, not_equal, great_a, great_b}
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  comparator_seq #(.WIDTH(8), .EARLY_EXIT(1)) u_dut8e (
    .i_clk(clk), .i_rst(rst), .i_start(start_r[0]), .i_signed(sgn), .i_a(a8), .i_b(b8),
    .o_busy(busy_w[0]), .o_done(done_w[0]), .o_equal(eq_w[0]), .o_not_equal(ne_w[0]),
    .o_great_a(ga_w[0]), .o_great_b(gb_w[0])
  );

  comparator_seq #(.WIDTH(8), .EARLY_EXIT(0)) u_dut8n (
    .i_clk(clk), .i_rst(rst), .i_start(start_r[1]), .i_signed(sgn), .i_a(a8), .i_b(b8),
    .o_busy(busy_w[1]), .o_done(done_w[1]), .o_equal(eq_w[1]), .o_not_equal(ne_w[1]),
    .o_great_a(ga_w[1]), .o_great_b(gb_w[1])
  );

  comparator_seq #(.WIDTH(2), .EARLY_EXIT(1)) u_dut2e (
    .i_clk(clk), .i_rst(rst), .i_start(start_r[2]), .i_signed(sgn), .i_a(a2), .i_b(b2),
    .o_busy(busy_w[2]), .o_done(done_w[2]), .o_equal(eq_w[2]), .o_not_equal(ne_w[2]),
    .o_great_a(ga_w[2]), .o_great_b(gb_w[2])
  );

  comparator_seq #(.WIDTH(2), .EARLY_EXIT(0)) u_dut2n (
    .i_clk(clk), .i_rst(rst), .i_start(start_r[3]), .i_signed(sgn), .i_a(a2), .i_b(b2),
    .o_busy(busy_w[3]), .o_done(done_w[3]), .o_equal(eq_w[3]), .o_not_equal(ne_w[3]),
    .o_great_a(ga_w[3]), .o_great_b(gb_w[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] res_of(input int i);
    return {eq_w[i], ne_w[i], ga_w[i], gb_w[i]};
  endfunction

  // Monitor: every done pulse must match the oldest expected entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (done_w[i]) begin
          if (sb.size() == 0) begin
            chk($sformatf("unexpected_done_inst%0d", i), 1, 0);
          end else begin
            e = sb.pop_front();
            chk("done_instance", i, e.id);
            chk($sformatf("result_inst%0d", i), int'(res_of(i)), int'(e.res));
            chk($sformatf("done_cycle_inst%0d", i), cyc, e.done_cyc);
          end
        end
      end
    end
  end

  // Called at a negedge; returns just after the accepting edge
  task automatic start_cmp(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input int lat, input logic [3:0] res);
    exp_t e;
    a8 = a;
    b8 = b;
    a2 = a[1:0];
    b2 = b[1:0];
    sgn = s;
    start_r[id] = 1'b1;
    @(posedge clk);
    #1;
    start_r[id] = 1'b0;
    e.id       = id;
    e.res      = res;
    e.done_cyc = cyc + lat;
    sb.push_back(e);
  endtask

  // Waits for done (busy must stay high), then checks busy drops one cycle later
  task automatic wait_done(input int id);
    int n = 0;
    forever begin
      @(negedge clk);
      if (done_w[id]) break;
      chk("busy_during_cmp", int'(busy_w[id]), 1);
      n++;
      if (n > 40) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy_w[id]), 0);
  endtask

  function automatic logic [3:0] ref2(input int a, input int b, input int s);
    int av = (s != 0 && a >= 2) ? a - 4 : a;
    int bv = (s != 0 && b >= 2) ? b - 4 : b;
    if (av == bv) return 4'b1000;
    if (av > bv) return 4'b0110;
    return 4'b0101;
  endfunction

  initial begin
    int lat;
    rst = 1'b1;
    start_r = '0;
    sgn = 1'b0;
    a8 = '0;
    b8 = '0;
    a2 = '0;
    b2 = '0;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_outputs_inst%0d", i),
          int'({busy_w[i], done_w[i], res_of(i)}), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed 8-bit vectors
    start_cmp(0, 8'hA5, 8'hA5, 1'b0, 8, 4'b1000); wait_done(0);
    start_cmp(0, 8'h80, 8'h7F, 1'b0, 1, 4'b0110); wait_done(0);
    start_cmp(0, 8'h80, 8'h7F, 1'b1, 1, 4'b0101); wait_done(0);
    start_cmp(0, 8'h03, 8'h02, 1'b0, 8, 4'b0110); wait_done(0);
    start_cmp(1, 8'h80, 8'h7F, 1'b0, 8, 4'b0110); wait_done(1);
    start_cmp(1, 8'h80, 8'h7F, 1'b1, 8, 4'b0101); wait_done(1);
    start_cmp(0, 8'hFF, 8'hFE, 1'b1, 8, 4'b0110); wait_done(0);
    start_cmp(1, 8'hFF, 8'hFE, 1'b1, 8, 4'b0110); wait_done(1);
    chk("result_hold_equal", int'(eq_w[0]), 0);
    chk("result_hold_great_a", int'(ga_w[0]), 1);

    // Start pulses at edges 2 and 4 must be ignored
    start_cmp(0, 8'h3C, 8'h3D, 1'b0, 8, 4'b0101);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h80; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("no_queued_start_busy", int'(busy_w[0]), 0);

    // Reset asserted at edge 3 of a compare
    start_cmp(1, 8'h10, 8'h20, 1'b0, 8, 4'b0101);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_outputs", int'({busy_w[1], done_w[1], res_of(1)}), 0);
    sb.delete();
    @(negedge clk);
    chk("reset_hold_outputs", int'({busy_w[1], done_w[1], res_of(1)}), 0);
    rst = 1'b0;
    @(negedge clk);
    start_cmp(0, 8'h10, 8'h20, 1'b0, 3, 4'b0101); wait_done(0);

    // Exhaustive 2-bit sweep, both modes, both exit settings
    for (int id = 2; id < 4; id++) begin
      for (int s = 0; s < 2; s++) begin
        for (int a = 0; a < 4; a++) begin
          for (int b = 0; b < 4; b++) begin
            lat = (id == 2 && ((a >> 1) != (b >> 1))) ? 1 : 2;
            start_cmp(id, 8'(a), 8'(b), s[0], lat, ref2(a, b, s));
            wait_done(id);
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
